// File: rtl/hsv_encoder_decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hsv_encoder_decoder_pkg : phase codes and transition helpers for the quadrature decoder
// Rev 1.0
// ---------------------------------------------------------------------------
package hsv_encoder_decoder_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam int QCNT_W = 4;
  localparam logic signed [QCNT_W-1:0] DIR_CW  = 4'sd1;
  localparam logic signed [QCNT_W-1:0] DIR_CCW = -4'sd1;
  localparam logic signed [QCNT_W-1:0] QFULL   = 4'sd4;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_CW,
    MV_CCW,
    MV_ILLEGAL
  } move_e;

  typedef enum logic [0:0] {
    ST_UNPRIMED,
    ST_PRIMED
  } prime_e;

  function automatic logic [1:0] next_cw(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Gray-code neighbours: one bit changing is a quarter step, both is illegal
  function automatic move_e classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)          return MV_NONE;
    if (cur == ~prev)         return MV_ILLEGAL;
    if (cur == next_cw(prev)) return MV_CW;
    return MV_CCW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_encoder_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hsv_encoder_decoder_if : encoder inputs and control-value outputs of one rotary encoder
// Rev 1.0
// ---------------------------------------------------------------------------
interface hsv_encoder_decoder_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             clear;
  logic [WIDTH-1:0] value;
  logic             step_up;
  logic             step_down;
  logic             phase_err;

  modport master (
    output enc_a, enc_b, clear,
    input  value, step_up, step_down, phase_err
  );

  modport slave (
    input  enc_a, enc_b, clear,
    output value, step_up, step_down, phase_err
  );
endinterface
`default_nettype wire

// File: rtl/hsv_encoder_decoder_quad_phase.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hsv_encoder_decoder_quad_phase : quarter-step tracker producing detent pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module hsv_encoder_decoder_quad_phase
  import hsv_encoder_decoder_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic i_enc_a,
  input  wire logic i_enc_b,
  input  wire logic i_clear,
  output logic      o_det_up,
  output logic      o_det_dn,
  output logic      o_err
);

  prime_e                    r_state;
  prime_e                    w_state_nxt;
  logic [1:0]                r_prev;
  logic signed [QCNT_W-1:0]  r_qcnt;
  logic                      r_det_up;
  logic                      r_det_dn;
  logic                      r_err;

  logic [1:0]                w_cur;
  move_e                     w_move;
  logic signed [QCNT_W-1:0]  w_delta;
  logic signed [QCNT_W-1:0]  w_qsum;
  logic signed [QCNT_W-1:0]  w_qcnt_nxt;
  logic                      w_up_nxt;
  logic                      w_dn_nxt;
  logic                      w_err_nxt;

  assign w_cur  = {i_enc_a, i_enc_b};
  assign w_move = classify(r_prev, w_cur);
  assign w_qsum = r_qcnt + w_delta;

  always_comb begin
    w_state_nxt = ST_PRIMED;
    w_delta     = '0;
    w_qcnt_nxt  = r_qcnt;
    w_up_nxt    = 1'b0;
    w_dn_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (w_move)
      MV_CW:   w_delta = DIR_CW;
      MV_CCW:  w_delta = DIR_CCW;
      default: w_delta = '0;
    endcase
    if (r_state == ST_PRIMED) begin
      if (w_move == MV_ILLEGAL) begin
        w_err_nxt  = 1'b1;
        w_qcnt_nxt = '0;
      end else if (w_move != MV_NONE) begin
        // Rest position closes the detent whether it was full, partial or reversed
        if (w_cur == PH_00) begin
          w_qcnt_nxt = '0;
          w_up_nxt   = (w_qsum == QFULL);
          w_dn_nxt   = (w_qsum == -QFULL);
        end else begin
          w_qcnt_nxt = w_qsum;
        end
      end
    end
    if (i_clear) begin
      w_qcnt_nxt = '0;
      w_up_nxt   = 1'b0;
      w_dn_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_UNPRIMED;
      r_prev   <= PH_00;
      r_qcnt   <= '0;
      r_det_up <= 1'b0;
      r_det_dn <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_cur;
      r_qcnt   <= w_qcnt_nxt;
      r_det_up <= w_up_nxt;
      r_det_dn <= w_dn_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_det_up = r_det_up;
  assign o_det_dn = r_det_dn;
  assign o_err    = r_err;

endmodule
`default_nettype wire

// File: rtl/hsv_encoder_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hsv_encoder_decoder : quadrature rotary-encoder decoder driving a bounded control value
// Rev 1.0
// ---------------------------------------------------------------------------
module hsv_encoder_decoder
  import hsv_encoder_decoder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int INIT    = 0,
  parameter int STEP    = 1,
  parameter int WRAP    = 0
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  hsv_encoder_decoder_if.slave  bus
);

  localparam int              EW        = WIDTH + 1;
  localparam logic [EW-1:0]   c_max     = EW'(MAX_VAL);
  localparam logic [EW-1:0]   c_step    = EW'(STEP);
  localparam logic [EW-1:0]   c_mod     = EW'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] c_init   = WIDTH'(INIT);

  logic             w_det_up;
  logic             w_det_dn;
  logic             w_det_err;
  logic [EW-1:0]    w_val_ext;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;

  logic [WIDTH-1:0] r_value;
  logic             r_step_up;
  logic             r_step_dn;
  logic             r_phase_err;

  hsv_encoder_decoder_quad_phase u_quad (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enc_a  (bus.enc_a),
    .i_enc_b  (bus.enc_b),
    .i_clear  (bus.clear),
    .o_det_up (w_det_up),
    .o_det_dn (w_det_dn),
    .o_err    (w_det_err)
  );

  assign w_val_ext = {1'b0, r_value};

  // One extra bit keeps value+STEP and value+MAX_VAL+1 from overflowing
  always_comb begin
    w_up_val = WIDTH'(c_max);
    if (w_val_ext <= c_max - c_step) begin
      w_up_val = WIDTH'(w_val_ext + c_step);
    end else if (WRAP != 0) begin
      w_up_val = WIDTH'(w_val_ext + c_step - c_mod);
    end
    w_dn_val = '0;
    if (w_val_ext >= c_step) begin
      w_dn_val = WIDTH'(w_val_ext - c_step);
    end else if (WRAP != 0) begin
      w_dn_val = WIDTH'(w_val_ext + c_mod - c_step);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value     <= c_init;
      r_step_up   <= 1'b0;
      r_step_dn   <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      r_phase_err <= w_det_err;
      r_step_up   <= w_det_up & ~bus.clear;
      r_step_dn   <= w_det_dn & ~bus.clear;
      if (bus.clear) begin
        r_value <= c_init;
      end else if (w_det_up) begin
        r_value <= w_up_val;
      end else if (w_det_dn) begin
        r_value <= w_dn_val;
      end
    end
  end

  assign bus.value     = r_value;
  assign bus.step_up   = r_step_up;
  assign bus.step_down = r_step_dn;
  assign bus.phase_err = r_phase_err;

endmodule
`default_nettype wire
